lcd_capture_if: RTL and testbench

- Receive-side counterpart of the LCD drive path. Captures the dual-pixel stream (valid, r0/g0/b0, r1/g1/b1) into an on-chip capture buffer.
- Exposes control/status registers and the captured pixels to the RISC-V over an AHB slave port.
- Used as the loopback sink for the brightness-adjusted LCD stream, so firmware and benches can read back and checksum a displayed frame.

---
 rtl/lcd_capture_if_pkg.sv | 75 +++++++
 rtl/lcd_capture_if_buffer.sv | 34 +++
 rtl/lcd_capture_if.sv | 271 +++++++++++++++++++++++++++
 tb/tb_lcd_capture_if.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_capture_if_pkg.sv
// Shared constants, register map, state encoding and helpers for the LCD capture sink.
package lcd_capture_if_pkg;

  // Bus and pixel geometry
  localparam int unsigned W_ADDR      = 32;
  localparam int unsigned W_DATA      = 32;
  localparam int unsigned W_WB_DATA   = 2;
  localparam int unsigned IMG_PIX_W   = 8;
  localparam int unsigned W_SIZE      = 12;
  localparam int unsigned N_PAIR      = 196608;
  localparam int unsigned W_PAIR      = 18;
  localparam int unsigned IMG_SEL_BIT = 20;
  localparam int unsigned DEF_WIDTH   = 768;
  localparam int unsigned DEF_HEIGHT  = 512;

  // One stored entry holds both pixels of a pair: {r0, g0, b0, r1, g1, b1}
  localparam int unsigned W_PIXPAIR = 6 * IMG_PIX_W;
  // Pair counter needs one spare bit so N_PAIR itself is representable with headroom
  localparam int unsigned W_CNT     = W_PAIR + 1;

  // AHB transfer types and responses
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  // System address map; the capture block decodes only its low 22 address bits
  localparam logic [W_ADDR-1:0] LCD_DRIVE_BASE   = 32'h4400_0000;
  localparam logic [W_ADDR-1:0] LCD_CAPTURE_BASE = 32'h4800_0000;

  // Register word offsets
  localparam logic [3:0] REG_WIDTH      = 4'd0;
  localparam logic [3:0] REG_HEIGHT     = 4'd1;
  localparam logic [3:0] REG_ARM        = 4'd2;
  localparam logic [3:0] REG_STATUS     = 4'd3;
  localparam logic [3:0] REG_PAIR_COUNT = 4'd4;
  localparam logic [3:0] REG_CHECKSUM   = 4'd5;
  localparam logic [3:0] REG_CLEAR      = 4'd6;

  // STATUS bit positions
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_OVF  = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } cap_state_e;

  // Sum of the six channel bytes of one pair
  function automatic logic [IMG_PIX_W+2:0] pair_sum(input logic [W_PIXPAIR-1:0] pair);
    logic [IMG_PIX_W+2:0] acc;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      acc = acc + (IMG_PIX_W+3)'(pair[i*IMG_PIX_W +: IMG_PIX_W]);
    end
    return acc;
  endfunction

  // Pairs in a WIDTH x HEIGHT frame, saturated to the buffer depth
  function automatic logic [W_CNT-1:0] target_pairs(input logic [W_SIZE-1:0] w,
                                                    input logic [W_SIZE-1:0] h);
    logic [2*W_SIZE-1:0] prod;
    prod = (2*W_SIZE)'(w) * (2*W_SIZE)'(h);
    prod = prod >> 1;
    if (prod > (2*W_SIZE)'(N_PAIR)) begin
      return W_CNT'(N_PAIR);
    end
    return prod[W_CNT-1:0];
  endfunction

endpackage

// File: rtl/lcd_capture_if_buffer.sv
// Capture buffer: simple dual-port RAM, one write port, one registered read port.
// A read and a write to the same entry in one cycle return the previous contents.
module lcd_capture_if_buffer
  import lcd_capture_if_pkg::*;
#(
  parameter int unsigned Depth = N_PAIR,
  parameter int unsigned Width = W_PIXPAIR,
  parameter int unsigned AddrW = W_PAIR
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Read and write in one block with non-blocking updates gives read-first behaviour
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_capture_if.sv
// LCD capture sink: records the dual-pixel stream into a buffer and exposes control,
// status, checksum and the captured pixels over an AHB slave port.
module lcd_capture_if
  import lcd_capture_if_pkg::*;
(
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 sl_HREADY,
  input  logic                 sl_HSEL,
  input  logic [1:0]           sl_HTRANS,
  input  logic [2:0]           sl_HBURST,
  input  logic [2:0]           sl_HSIZE,
  input  logic [W_ADDR-1:0]    sl_HADDR,
  input  logic                 sl_HWRITE,
  input  logic [W_DATA-1:0]    sl_HWDATA,
  output logic                 out_sl_HREADY,
  output logic [1:0]           out_sl_HRESP,
  output logic [W_DATA-1:0]    out_sl_HRDATA,
  input  logic                 in_valid,
  input  logic [IMG_PIX_W-1:0] in_r0,
  input  logic [IMG_PIX_W-1:0] in_g0,
  input  logic [IMG_PIX_W-1:0] in_b0,
  input  logic [IMG_PIX_W-1:0] in_r1,
  input  logic [IMG_PIX_W-1:0] in_g1,
  input  logic [IMG_PIX_W-1:0] in_b1
);

  // Burst type, size and the unused address/data bits carry no meaning here
  logic unused_bus;
  assign unused_bus = ^{sl_HBURST, sl_HSIZE, sl_HADDR, sl_HWDATA};

  assign out_sl_HREADY = 1'b1;
  assign out_sl_HRESP  = HRESP_OKAY;

  // ---------------------------------------------------------------------------
  // Address phase decode
  // ---------------------------------------------------------------------------
  logic              ahb_accept;
  logic              addr_img;
  logic [W_PAIR:0]   pix_idx;
  logic [W_PAIR-1:0] pair_idx;
  logic              pair_oob;

  assign ahb_accept = sl_HSEL & sl_HREADY &
                      ((sl_HTRANS == HTRANS_NONSEQ) | (sl_HTRANS == HTRANS_SEQ));
  assign addr_img   = sl_HADDR[IMG_SEL_BIT];

  // The window-select bit sits inside the natural pixel-index field, so its place is
  // taken by the next address bit up; this keeps all N_PAIR pairs addressable.
  assign pix_idx  = {sl_HADDR[IMG_SEL_BIT+1], sl_HADDR[IMG_SEL_BIT-1:W_WB_DATA]};
  assign pair_idx = pix_idx[W_PAIR:1];
  assign pair_oob = (pair_idx >= W_PAIR'(N_PAIR));

  // ---------------------------------------------------------------------------
  // Data phase state
  // ---------------------------------------------------------------------------
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic [3:0] reg_sel_q, reg_sel_d;
  logic       img_rd_q, img_rd_d;
  logic       img_half_q, img_half_d;
  logic       img_oob_q, img_oob_d;

  // Register window accesses latch offset and direction; image reads latch pixel half
  always_comb begin
    reg_wr_d   = 1'b0;
    reg_rd_d   = 1'b0;
    reg_sel_d  = reg_sel_q;
    img_rd_d   = 1'b0;
    img_half_d = img_half_q;
    img_oob_d  = img_oob_q;
    if (ahb_accept) begin
      if (addr_img) begin
        img_rd_d   = ~sl_HWRITE;
        img_half_d = pix_idx[0];
        img_oob_d  = pair_oob;
      end else begin
        reg_wr_d  = sl_HWRITE;
        reg_rd_d  = ~sl_HWRITE;
        reg_sel_d = sl_HADDR[5:2];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration and capture state
  // ---------------------------------------------------------------------------
  cap_state_e               state_q, state_d;
  logic [W_SIZE-1:0]        width_q, width_d;
  logic [W_SIZE-1:0]        height_q, height_d;
  logic [W_CNT-1:0]         cnt_q, cnt_d;
  logic [W_CNT-1:0]         target_q, target_d;
  logic [W_DATA-1:0]        csum_q, csum_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;

  logic                     arm_pulse;
  logic                     clr_pulse;
  logic                     cfg_open;
  logic [W_CNT-1:0]         target_calc;
  logic [W_PIXPAIR-1:0]     cap_pair;
  logic                     cap_we;
  logic [W_PAIR-1:0]        cap_waddr;

  assign arm_pulse   = reg_wr_q & (reg_sel_q == REG_ARM) & sl_HWDATA[0];
  assign clr_pulse   = reg_wr_q & (reg_sel_q == REG_CLEAR) & sl_HWDATA[0];
  assign cfg_open    = (state_q == StIdle) | (state_q == StDone);
  assign target_calc = target_pairs(width_q, height_q);
  assign cap_pair    = {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1};
  // Entry written is always the running pair count (zero while armed)
  assign cap_waddr   = cnt_q[W_PAIR-1:0];

  // Frame geometry may only change while no capture is in flight
  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    if (reg_wr_q && cfg_open) begin
      if (reg_sel_q == REG_WIDTH) begin
        width_d = sl_HWDATA[W_SIZE-1:0];
      end
      if (reg_sel_q == REG_HEIGHT) begin
        height_d = sl_HWDATA[W_SIZE-1:0];
      end
    end
  end

  // Capture sequencing: clear has priority over everything, including a same-cycle arm
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    csum_d   = csum_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    cap_we   = 1'b0;
    if (clr_pulse) begin
      state_d = StIdle;
      cnt_d   = '0;
      csum_d  = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_pulse) begin
            cnt_d    = '0;
            csum_d   = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            target_d = target_calc;
            if (target_calc == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StArmed;
            end
          end else if ((state_q == StDone) && in_valid) begin
            ovf_d = 1'b1;
          end
        end
        StArmed, StCapture: begin
          if (in_valid) begin
            cap_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            csum_d = csum_q + W_DATA'(pair_sum(cap_pair));
            if (cnt_d == target_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StCapture;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // All block state, synchronous active-high reset
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      reg_wr_q   <= 1'b0;
      reg_rd_q   <= 1'b0;
      reg_sel_q  <= '0;
      img_rd_q   <= 1'b0;
      img_half_q <= 1'b0;
      img_oob_q  <= 1'b0;
      state_q    <= StIdle;
      width_q    <= W_SIZE'(DEF_WIDTH);
      height_q   <= W_SIZE'(DEF_HEIGHT);
      cnt_q      <= '0;
      target_q   <= '0;
      csum_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      reg_wr_q   <= reg_wr_d;
      reg_rd_q   <= reg_rd_d;
      reg_sel_q  <= reg_sel_d;
      img_rd_q   <= img_rd_d;
      img_half_q <= img_half_d;
      img_oob_q  <= img_oob_d;
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      csum_q     <= csum_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture buffer
  // ---------------------------------------------------------------------------
  logic                 buf_re;
  logic [W_PIXPAIR-1:0] buf_rdata;

  assign buf_re = ahb_accept & addr_img & ~sl_HWRITE & ~pair_oob;

  lcd_capture_if_buffer #(
    .Depth (N_PAIR),
    .Width (W_PIXPAIR),
    .AddrW (W_PAIR)
  ) u_buffer (
    .clk_i   (HCLK),
    .we_i    (cap_we),
    .waddr_i (cap_waddr),
    .wdata_i (cap_pair),
    .re_i    (buf_re),
    .raddr_i (pair_idx),
    .rdata_o (buf_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  logic [W_DATA-1:0] reg_rdata;
  logic [2:0]        status;

  assign status = {ovf_q, done_q, (state_q == StArmed) | (state_q == StCapture)};

  // Register read mux from the latched offset; unmapped offsets read zero
  always_comb begin
    reg_rdata = '0;
    case (reg_sel_q)
      REG_WIDTH:      reg_rdata = W_DATA'(width_q);
      REG_HEIGHT:     reg_rdata = W_DATA'(height_q);
      REG_ARM:        reg_rdata = W_DATA'(state_q == StArmed);
      REG_STATUS:     reg_rdata = W_DATA'(status);
      REG_PAIR_COUNT: reg_rdata = W_DATA'(cnt_q);
      REG_CHECKSUM:   reg_rdata = csum_q;
      default:        reg_rdata = '0;
    endcase
  end

  // Data-phase output selection; zero whenever no read is in its data phase
  always_comb begin
    out_sl_HRDATA = '0;
    if (img_rd_q) begin
      if (!img_oob_q) begin
        out_sl_HRDATA = img_half_q ? {8'h00, buf_rdata[3*IMG_PIX_W-1:0]}
                                   : {8'h00, buf_rdata[W_PIXPAIR-1:3*IMG_PIX_W]};
      end
    end else if (reg_rd_q) begin
      out_sl_HRDATA = reg_rdata;
    end
  end

endmodule

// File: tb/tb_lcd_capture_if.sv
// Self-checking bench for lcd_capture_if against a frame-level reference model.
module tb_lcd_capture_if;
  import lcd_capture_if_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sl_HREADY, sl_HSEL, sl_HWRITE;
  logic [1:0]  sl_HTRANS;
  logic [2:0]  sl_HBURST, sl_HSIZE;
  logic [31:0] sl_HADDR, sl_HWDATA;
  logic        out_sl_HREADY;
  logic [1:0]  out_sl_HRESP;
  logic [31:0] out_sl_HRDATA;
  logic        in_valid;
  logic [7:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;

  lcd_capture_if dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .sl_HREADY     (sl_HREADY),
    .sl_HSEL       (sl_HSEL),
    .sl_HTRANS     (sl_HTRANS),
    .sl_HBURST     (sl_HBURST),
    .sl_HSIZE      (sl_HSIZE),
    .sl_HADDR      (sl_HADDR),
    .sl_HWRITE     (sl_HWRITE),
    .sl_HWDATA     (sl_HWDATA),
    .out_sl_HREADY (out_sl_HREADY),
    .out_sl_HRESP  (out_sl_HRESP),
    .out_sl_HRDATA (out_sl_HRDATA),
    .in_valid      (in_valid),
    .in_r0         (in_r0),
    .in_g0         (in_g0),
    .in_b0         (in_b0),
    .in_r1         (in_r1),
    .in_g1         (in_g1),
    .in_b1         (in_b1)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: frame geometry, capture progress and stored pairs
  int          m_width, m_height, m_target, m_count;
  bit          m_running, m_done, m_ovf;
  logic [31:0] m_sum;
  logic [47:0] m_buf [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] reg_addr(input int off);
    return LCD_CAPTURE_BASE + 32'(off * 4);
  endfunction

  // Pixel p lives at word p of the image window; pixel-index bit 18 maps to address bit 21
  function automatic logic [31:0] img_addr(input int p);
    logic [31:0] a;
    a = LCD_CAPTURE_BASE | 32'h0010_0000;
    a = a | (32'(p % 262144) << 2);
    if ((p / 262144) % 2 == 1) a = a | 32'h0020_0000;
    return a;
  endfunction

  function automatic logic [31:0] model_pixel(input int p);
    logic [47:0] d;
    d = m_buf[p / 2];
    return (p % 2 == 0) ? {8'h00, d[47:24]} : {8'h00, d[23:0]};
  endfunction

  function automatic logic [31:0] byte_sum(input logic [47:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += int'(d[i*8 +: 8]);
    return 32'(s);
  endfunction

  function automatic logic [31:0] model_status();
    return {29'b0, m_ovf, m_done, m_running};
  endfunction

  task automatic model_clear();
    m_running = 0; m_done = 0; m_ovf = 0; m_count = 0; m_sum = 0;
  endtask

  task automatic model_reg_write(input int off, input logic [31:0] d);
    case (off)
      0: if (!m_running) m_width = int'(d[11:0]);
      1: if (!m_running) m_height = int'(d[11:0]);
      2: if (d[0] && !m_running) begin
        model_clear();
        m_target = (m_width * m_height) / 2;
        if (m_target > int'(N_PAIR)) m_target = int'(N_PAIR);
        if (m_target == 0) m_done = 1;
        else m_running = 1;
      end
      6: if (d[0]) model_clear();
      default: ;
    endcase
  endtask

  task automatic model_push(input logic [47:0] d);
    if (m_running) begin
      m_buf[m_count] = d;
      m_count++;
      m_sum = m_sum + byte_sum(d);
      if (m_count == m_target) begin
        m_running = 0;
        m_done = 1;
      end
    end else if (m_done) begin
      m_ovf = 1;
    end
  endtask

  task automatic bus_idle();
    sl_HSEL = 1'b0; sl_HTRANS = HTRANS_IDLE; sl_HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input int off, input logic [31:0] d);
    @(negedge HCLK);
    in_valid = 1'b0;
    sl_HSEL = 1'b1; sl_HTRANS = HTRANS_NONSEQ; sl_HADDR = reg_addr(off); sl_HWRITE = 1'b1;
    @(negedge HCLK);
    bus_idle();
    sl_HWDATA = d;
    model_reg_write(off, d);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    in_valid = 1'b0;
    sl_HSEL = 1'b1; sl_HTRANS = HTRANS_NONSEQ; sl_HADDR = a; sl_HWRITE = 1'b0;
    @(negedge HCLK);
    bus_idle();
    d = out_sl_HRDATA;
  endtask

  task automatic check_reg(input string tag, input int off, input logic [31:0] exp);
    logic [31:0] v;
    ahb_read(reg_addr(off), v);
    check(tag, v, exp);
  endtask

  task automatic check_state(input string tag);
    check_reg({tag, "_status"}, 3, model_status());
    check_reg({tag, "_count"}, 4, 32'(m_count));
    check_reg({tag, "_csum"}, 5, m_sum);
  endtask

  task automatic check_pixels(input string tag, input int npix);
    logic [31:0] v;
    for (int p = 0; p < npix; p++) begin
      if (m_buf.exists(p / 2)) begin
        ahb_read(img_addr(p), v);
        check($sformatf("%s_pix%0d", tag, p), v, model_pixel(p));
      end
    end
  endtask

  task automatic push_pair(input logic [47:0] d);
    @(negedge HCLK);
    in_valid = 1'b1;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = d;
    model_push(d);
  endtask

  task automatic gap();
    @(negedge HCLK);
    in_valid = 1'b0;
  endtask

  function automatic logic [47:0] rnd_pair();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1; in_valid = 1'b0; bus_idle();
    repeat (2) @(negedge HCLK);
    check("rdata_in_reset", out_sl_HRDATA, 32'h0);
    HRESET = 1'b0;
    m_width = int'(DEF_WIDTH); m_height = int'(DEF_HEIGHT);
    model_clear();
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] old_pix;
    logic [47:0] d;
    int w, h, t;

    HRESET = 1'b0; sl_HREADY = 1'b1; sl_HBURST = 3'b000; sl_HSIZE = 3'b010;
    sl_HADDR = '0; sl_HWDATA = '0; in_valid = 1'b0;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = '0;
    bus_idle();

    // Reset state
    do_reset();
    check("hready", 32'(out_sl_HREADY), 32'h1);
    check("hresp", 32'(out_sl_HRESP), 32'h0);
    check_reg("rst_width", 0, 32'd768);
    check_reg("rst_height", 1, 32'd512);
    check_state("rst");
    check_reg("rst_unmapped", 9, 32'h0);

    // 4x2 frame with a one-cycle gap after pair 1
    ahb_write(0, 32'd4);
    ahb_write(1, 32'd2);
    ahb_write(2, 32'd1);
    check_reg("armed_flag", 2, 32'(m_running && m_count == 0));
    check_reg("armed_status", 3, 32'h1);
    push_pair(rnd_pair());
    push_pair(rnd_pair());
    gap();
    push_pair(rnd_pair());
    push_pair(rnd_pair());
    check_state("f1");
    check_reg("f1_status_lit", 3, 32'h2);
    check_pixels("f1", 8);

    // Extra pair after DONE -> overflow, buffer unchanged
    push_pair(rnd_pair());
    check_state("ovf");
    check_reg("ovf_status_lit", 3, 32'h6);
    check_pixels("ovf", 8);

    // All-0x01 frame: checksum 24
    ahb_write(2, 32'd1);
    for (int i = 0; i < 4; i++) push_pair(48'h0101_0101_0101);
    check_reg("csum24", 5, 32'd24);
    check_state("ones");

    // Abort by CLEAR, then a full frame
    ahb_write(2, 32'd1);
    push_pair(rnd_pair());
    push_pair(rnd_pair());
    ahb_write(6, 32'd1);
    check_state("clr");
    ahb_write(2, 32'd1);
    for (int i = 0; i < 4; i++) push_pair(rnd_pair());
    check_state("rearm");
    check_pixels("rearm", 8);

    // Geometry write ignored mid-capture; CLEAR after ARM ends idle
    ahb_write(2, 32'd1);
    push_pair(rnd_pair());
    ahb_write(0, 32'd8);
    check_reg("width_locked", 0, 32'(m_width));
    ahb_write(2, 32'd1);
    ahb_write(6, 32'd1);
    check_state("armclr");
    check_reg("armclr_flag", 2, 32'h0);

    // Zero-size frame completes at ARM
    ahb_write(0, 32'd0);
    ahb_write(2, 32'd1);
    check_state("zero");

    // Randomized frames with random blanking gaps and occasional overflow pairs
    for (int f = 0; f < 6; f++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      ahb_write(0, 32'(w));
      ahb_write(1, 32'(h));
      ahb_write(2, 32'd1);
      t = m_target;
      for (int i = 0; i < t; i++) begin
        push_pair(rnd_pair());
        if ($urandom_range(0, 3) == 0) gap();
      end
      if ($urandom_range(0, 1) == 1) push_pair(rnd_pair());
      check_state($sformatf("rnd%0d", f));
      check_pixels($sformatf("rnd%0d", f), 2 * t);
    end

    // Same-cycle capture write and image read of pair 0 returns the old pixel
    ahb_write(0, 32'd4);
    ahb_write(1, 32'd2);
    old_pix = model_pixel(0);
    ahb_write(2, 32'd1);
    d = rnd_pair();
    @(negedge HCLK);
    sl_HSEL = 1'b1; sl_HTRANS = HTRANS_NONSEQ; sl_HADDR = img_addr(0); sl_HWRITE = 1'b0;
    in_valid = 1'b1;
    {in_r0, in_g0, in_b0, in_r1, in_g1, in_b1} = d;
    model_push(d);
    @(negedge HCLK);
    bus_idle();
    in_valid = 1'b0;
    check("read_first", out_sl_HRDATA, old_pix);
    check_pixels("after_coll", 2);

    // Reset mid-capture
    push_pair(rnd_pair());
    do_reset();
    check_reg("mid_rst_width", 0, 32'd768);
    check_reg("mid_rst_height", 1, 32'd512);
    check_state("mid_rst");
    ahb_read(img_addr(2 * int'(N_PAIR)), v);
    check("oob_pair", v, 32'h0);
    ahb_read(img_addr(2 * int'(N_PAIR) + 1), v);
    check("oob_pair_odd", v, 32'h0);
    check_pixels("kept", 4);

    repeat (2) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
